// File: rtl/inst_mem_pkg.sv
// Shared types and default widths for the instruction memory and its loader.
// ST_CHECK exists only when LOADER_CHECKSUM_EN is defined.
package inst_mem_pkg;

  localparam int unsigned DEFAULT_W          = 32;
  localparam int unsigned DEFAULT_DEPTH_LOG2 = 10;
  localparam int unsigned BYTES_PER_WORD     = DEFAULT_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3
`ifdef LOADER_CHECKSUM_EN
    ,
    ST_CHECK = 3'd4
`endif
  } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Assembles a little-endian word from a byte stream: byte counter, shift register
// and a same-cycle strobe on the byte that completes the word.
module byte_packer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             accept_i,
  input  logic [7:0]       byte_i,
  output logic [WIDTH-1:0] word_c_o,
  output logic             last_c_o
);

  localparam int unsigned BPW = WIDTH / 8;
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sr_q;

  // New bytes enter at the top so the first byte ends up in the low lane.
  assign word_c_o = {byte_i, sr_q[WIDTH-1:8]};
  assign last_c_o = accept_i && (cnt_q == CW'(BPW - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
      sr_q  <= '0;
    end else if (accept_i) begin
      sr_q  <= word_c_o;
      cnt_q <= last_c_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/inst_mem_loader.sv
// Program loader: streams bytes into little-endian words and writes them to
// consecutive word addresses. LOADER_CHECKSUM_EN adds a trailing checksum word.
module inst_mem_loader
  import inst_mem_pkg::*;
#(
  parameter int unsigned W          = DEFAULT_W,
  parameter int unsigned AW         = 32,
  parameter int unsigned DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DEPTH_LOG2:0] num_words,
  input  logic                byte_valid,
  input  logic [7:0]          byte_data,
  output logic                byte_ready,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [W-1:0]        mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold
);

  localparam int unsigned IW = DEPTH_LOG2 + 1;

  loader_state_t state_q;
  logic [IW-1:0] num_q;
  logic [IW-1:0] word_idx_q;
  logic          byte_ready_q;
  logic          mem_we_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;
  logic [AW-1:0] mem_addr_q;
  logic [W-1:0]  mem_wdata_q;
`ifdef LOADER_CHECKSUM_EN
  logic [W-1:0]  sum_q;
`endif

  logic          idle_c;
  logic          count_bad_c;
  logic          accept_c;
  logic          pk_last_c;
  logic [W-1:0]  pk_word_c;
  logic [IW-1:0] word_idx_inc_c;

  assign idle_c         = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign count_bad_c    = (num_words == '0) || (num_words > IW'(2 ** DEPTH_LOG2));
  assign accept_c       = byte_valid && byte_ready_q;
  assign word_idx_inc_c = word_idx_q + 1'b1;

  byte_packer #(
    .WIDTH(W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (start && idle_c),
    .accept_i(accept_c),
    .byte_i  (byte_data),
    .word_c_o(pk_word_c),
    .last_c_o(pk_last_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      num_q        <= '0;
      word_idx_q   <= '0;
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (count_bad_c) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              error_q <= 1'b1;
            end else begin
              state_q      <= ST_LOAD;
              num_q        <= num_words;
              word_idx_q   <= '0;
              byte_ready_q <= 1'b1;
              busy_q       <= 1'b1;
              done_q       <= 1'b0;
              error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
              sum_q        <= '0;
`endif
            end
          end
        end
        ST_LOAD: begin
          if (pk_last_c) begin
            state_q      <= ST_WRITE;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b1;
            mem_addr_q   <= AW'(word_idx_q) * AW'(BYTES_PER_WORD);
            mem_wdata_q  <= pk_word_c;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_q + pk_word_c;
`endif
          end
        end
        ST_WRITE: begin
          word_idx_q   <= word_idx_inc_c;
          byte_ready_q <= 1'b1;
          if (word_idx_inc_c == num_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= ST_CHECK;
`else
            state_q      <= ST_DONE;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
`endif
          end else begin
            state_q <= ST_LOAD;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        // Trailing word is compared, never written.
        ST_CHECK: begin
          if (pk_last_c) begin
            state_q      <= ST_DONE;
            byte_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b1;
            error_q      <= (pk_word_c != sum_q);
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign byte_ready = byte_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;
  assign cpu_hold   = busy_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule
